pipe_sequencer: RTL and testbench
=================================

# pipe_sequencer

Pipeline sequencing controller for the 9-bit-instruction processor. It sits beside the decoder and drives the PC enable, the IF/ID and ID/EX register enables, and the flush controls. It starts a program on `start`, stalls on load-use hazards for a fixed load latency, and flushes the wrong-path instructions on a taken branch. On `DNE` it drains the pipe and raises `done`, and it counts stall and flush cycles for performance debug.

## Interface
Parameters:
- `OPW`, 4: opcode field width
- `RAW`, 3: operand A register pointer width
- `RBW`, 2: operand B register pointer width
- `LD_LAT`, 2: load-use stall length in cycles, ≥1
- `DRAIN_CYC`, 2: cycles to empty ID/EX/WB after `DNE`, ≥1
- `CNTW`, 16: performance counter width

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin or restart program; sampled in IDLE or DONE
- `idUsesA`, `idUsesB`  in  1  decode-stage instruction reads operand A / B
- `idPtrA`  in  RAW  decode-stage source A pointer
- `idPtrB`  in  RBW  decode-stage source B pointer, zero-extended to RAW for compares
- `idAck`  in  1  decode-stage instruction is `DNE`
- `exMemLd`  in  1  execute-stage instruction is a load
- `exDst`  in  RAW  execute-stage destination pointer
- `exJmp`  in  1  execute-stage branch resolved taken
- `pcClr`  out  1  one-cycle pulse that zeroes the PC on program start
- `pcEn`  out  1  PC advance/load enable
- `ifIdEn`  out  1  IF/ID register load enable
- `ifIdFlush`  out  1  IF/ID register loads a NOP
- `idExFlush`  out  1  ID/EX register loads a bubble
- `busy`  out  1  state is RUN, STALL or DRAIN
- `done`  out  1  program complete, held high
- `stallCnt`, `flushCnt`  out  CNTW  stall cycles / taken-branch flushes since start

## Operation
States: IDLE, RUN, STALL, DRAIN, DONE.
- IDLE: all enables and flushes are 0. `start=1` moves to RUN, pulses `pcClr`, and clears both counters.
- RUN: `pcEn=ifIdEn=1` by default. Priority is `exJmp` > hazard > `idAck`.
  - `exJmp`: `ifIdFlush=idExFlush=1`, `pcEn=1` so the PC loads the target, `flushCnt++`. State stays RUN.
  - hazard = `exMemLd && ((idUsesA && idPtrA==exDst) || (idUsesB && {0,idPtrB}==exDst))`. Response: `pcEn=ifIdEn=0`, `idExFlush=1`, `stallCnt++`, load internal count with 1, go to STALL when `LD_LAT>1`, otherwise stay RUN.
  - `idAck`, with no jump and no hazard: `pcEn=ifIdEn=0`, `ifIdFlush=1`. Load drain count with 0 and go to DRAIN.
- STALL: `pcEn=ifIdEn=0`, `idExFlush=1`, `stallCnt++` every cycle. When the count reaches `LD_LAT-1`, return to RUN. `exJmp` and `idAck` are ignored.
- DRAIN: all enables are 0 and flushes are 0. Count up; at `DRAIN_CYC-1` go to DONE. `exJmp` is ignored because nothing older than `DNE` remains.
- DONE: `done=1` and enables are 0. `start=1` behaves exactly like the start from IDLE.
- Counters saturate at all-ones and never wrap.
- `rst` in any state, including mid-STALL or mid-DRAIN: next state is IDLE, all counters 0, `pcClr=0`.

## Timing
- Reset values: state IDLE. `pcClr`, `pcEn`, `ifIdEn`, `ifIdFlush`, `idExFlush`, `busy` and `done` are 0. `stallCnt=flushCnt=0`.
- `pcEn`, `ifIdEn`, `ifIdFlush` and `idExFlush` are combinational (Mealy) from the state and same-cycle inputs. They are valid before the edge that uses them.
- `pcClr`, `busy`, `done` and the counters are registered.
  - `pcClr` is high for the first cycle in RUN.
  - `busy` rises on that same cycle.
- Load-use penalty is exactly `LD_LAT` cycles of `pcEn=0`.
- Taken-branch penalty is 2 squashed slots, with no extra stall cycle.
- `done` rises exactly `DRAIN_CYC+1` cycles after the `idAck` cycle.
- Simultaneous `exJmp` and `idAck` in RUN: the flush wins, `DNE` is squashed, and the block stays RUN.
- `start` held high in RUN, STALL or DRAIN has no effect.

## Test plan
- Reset, then `start=1` for 1 cycle → `pcClr=1` and `busy=1` on the next cycle, `pcEn=1`, counters 0.
- In RUN, `exMemLd=1`, `exDst=3`, `idUsesA=1`, `idPtrA=3` with `LD_LAT=2` → `pcEn=0` for exactly 2 cycles, `idExFlush=1` both cycles, `stallCnt=2`. Repeat with `idUsesA=0` → no stall.
- `exJmp=1` for 1 cycle → `ifIdFlush=idExFlush=1` and `pcEn=1` that cycle, `flushCnt=1`, state RUN. Also assert `exJmp` together with `idAck=1` → no DRAIN and `done` stays 0.
- `idAck=1` with `DRAIN_CYC=2` → `pcEn=0` from that cycle, `done=1` 3 cycles later and held. Then `start=1` → counters 0 and `busy=1`.
- Assert `rst` during the second STALL cycle → next cycle IDLE, all outputs 0. `start` then restarts cleanly.
- Force `stallCnt` near all-ones (e.g. `CNTW=4`, 16+ stall cycles) → value holds at 15.

Source files
------------

// File: rtl/pipe_sequencer_if.sv
// Pipeline sequencer bus: decode/execute hazard inputs, program start, and the
// pipe-control, status and performance-counter outputs.
//   master : the sequencer side (drives pipe controls, status and counters)
//   slave  : the pipeline / host side (drives start plus decode/execute info)
interface pipe_sequencer_if #(
  parameter int RAW  = 3,
  parameter int RBW  = 2,
  parameter int CNTW = 16
);
  logic            start;
  logic            idUsesA;
  logic            idUsesB;
  logic [RAW-1:0]  idPtrA;
  logic [RBW-1:0]  idPtrB;
  logic            idAck;
  logic            exMemLd;
  logic [RAW-1:0]  exDst;
  logic            exJmp;
  logic            pcClr;
  logic            pcEn;
  logic            ifIdEn;
  logic            ifIdFlush;
  logic            idExFlush;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] stallCnt;
  logic [CNTW-1:0] flushCnt;

  modport master (
    input  start, idUsesA, idUsesB, idPtrA, idPtrB, idAck, exMemLd, exDst, exJmp,
    output pcClr, pcEn, ifIdEn, ifIdFlush, idExFlush, busy, done, stallCnt, flushCnt
  );

  modport slave (
    output start, idUsesA, idUsesB, idPtrA, idPtrB, idAck, exMemLd, exDst, exJmp,
    input  pcClr, pcEn, ifIdEn, ifIdFlush, idExFlush, busy, done, stallCnt, flushCnt
  );
endinterface

// File: rtl/pipe_sequencer.sv
// Pipeline sequencing controller for the 9-bit-instruction processor.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : pipe_sequencer_if.master
//              in  start, idUsesA/B, idPtrA/B, idAck, exMemLd, exDst, exJmp
//              out pcClr, pcEn, ifIdEn, ifIdFlush, idExFlush (Mealy pipe controls),
//                  busy, done, stallCnt, flushCnt (registered)
module pipe_sequencer #(
  parameter int OPW       = 4,
  parameter int RAW       = 3,
  parameter int RBW       = 2,
  parameter int LD_LAT    = 2,
  parameter int DRAIN_CYC = 2,
  parameter int CNTW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_sequencer_if.master bus
);

  localparam int MAXC = (LD_LAT > DRAIN_CYC) ? LD_LAT : DRAIN_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  generate
    if (OPW < 1 || RBW > RAW || LD_LAT < 1 || DRAIN_CYC < 1 || CNTW < 1) begin : g_bad_param
      $error("pipe_sequencer: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RUN, STALL, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
  logic            pc_clr_q, pc_clr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hazard;
  logic            pc_en, if_id_en, if_id_flush, id_ex_flush;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // B pointer is narrower than the destination field: zero-extend before compare
  always_comb begin
    hazard = bus.exMemLd &&
             ((bus.idUsesA && (bus.idPtrA == bus.exDst)) ||
              (bus.idUsesB && (RAW'(bus.idPtrB) == bus.exDst)));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          stall_cnt_d = '0;
          flush_cnt_d = '0;
        end
      end
      RUN: begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        if (bus.exJmp) begin
          // PC keeps its enable so the branch target loads this cycle
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
          cnt_d       = CW'(1);
          if (LD_LAT > 1) state_d = STALL;
        end else if (bus.idAck) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          if_id_flush = 1'b1;
          cnt_d       = '0;
          state_d     = DRAIN;
        end
      end
      STALL: begin
        id_ex_flush = 1'b1;
        stall_cnt_d = sat_inc(stall_cnt_q);
        if (cnt_q == CW'(LD_LAT - 1)) state_d = RUN;
        else                           cnt_d   = cnt_q + CW'(1);
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) state_d = DONE;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    pc_clr_d = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    busy_d   = (state_d == RUN) || (state_d == STALL) || (state_d == DRAIN);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      pc_clr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pc_clr_q    <= pc_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pcEn      = pc_en;
  assign bus.ifIdEn    = if_id_en;
  assign bus.ifIdFlush = if_id_flush;
  assign bus.idExFlush = id_ex_flush;
  assign bus.pcClr     = pc_clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stallCnt  = stall_cnt_q;
  assign bus.flushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed table-driven bench for pipe_sequencer (LD_LAT=2, DRAIN_CYC=2, CNTW=4).
module tb_pipe_sequencer;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_sequencer_if #(.RAW(3), .RBW(2), .CNTW(CNTW)) bus ();

  pipe_sequencer #(
    .OPW(4), .RAW(3), .RBW(2), .LD_LAT(2), .DRAIN_CYC(2), .CNTW(CNTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic        rst, start, ua, ub;
    logic [2:0]  pa;
    logic [1:0]  pb;
    logic        ack, ld;
    logic [2:0]  dst;
    logic        jmp;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // {pcClr, pcEn, ifIdEn, ifIdFlush, idExFlush, busy, done, stallCnt, flushCnt}
  logic [14:0] act;
  assign act = {bus.pcClr, bus.pcEn, bus.ifIdEn, bus.ifIdFlush, bus.idExFlush,
                bus.busy, bus.done, bus.stallCnt, bus.flushCnt};

  function automatic vec_t mk(input logic r, s, ua, ub, input int pa, pb,
                              input logic ack, ld, input int dst, input logic jmp,
                              input logic c, e, i, f, x, b, d, input int sc, fc);
    vec_t t;
    t.rst = r; t.start = s; t.ua = ua; t.ub = ub;
    t.pa = 3'(pa); t.pb = 2'(pb); t.ack = ack; t.ld = ld;
    t.dst = 3'(dst); t.jmp = jmp;
    t.exp = {c, e, i, f, x, b, d, 4'(sc), 4'(fc)};
    return t;
  endfunction

  task automatic drive(input logic r, s, ua, ub, input logic [2:0] pa,
                       input logic [1:0] pb, input logic ack, ld,
                       input logic [2:0] dst, input logic jmp);
    rst = r; bus.start = s; bus.idUsesA = ua; bus.idUsesB = ub;
    bus.idPtrA = pa; bus.idPtrB = pb; bus.idAck = ack; bus.exMemLd = ld;
    bus.exDst = dst; bus.exJmp = jmp;
  endtask

  task automatic check(input string nm, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 3'd0, 0);
    repeat (2) @(posedge clk);

    //          r s ua ub pa pb ack ld dst jmp   C E I F X B D sc fc
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0, 0,0)); // reset state
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,  0,0,0,0,0,0,0, 0,0)); // idle ignores jmp
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0, 0,0)); // start
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  1,1,1,0,0,1,0, 0,0)); // first RUN cycle
    vecs.push_back(mk(0,0,1,0,3,0,0,1,3,0,  0,0,0,0,1,1,0, 0,0)); // load-use on A
    vecs.push_back(mk(0,0,1,0,3,0,1,1,3,1,  0,0,0,0,1,1,0, 1,0)); // STALL ignores jmp/ack
    vecs.push_back(mk(0,0,0,0,3,0,0,1,3,0,  0,1,1,0,0,1,0, 2,0)); // A not used: no stall
    vecs.push_back(mk(0,0,0,1,0,3,0,1,7,0,  0,1,1,0,0,1,0, 2,0)); // B=3 zero-ext != 7
    vecs.push_back(mk(0,0,0,1,0,3,0,1,3,0,  0,0,0,0,1,1,0, 2,0)); // load-use on B
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  0,0,0,0,1,1,0, 3,0)); // second stall cycle
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,  0,1,1,1,1,1,0, 4,0)); // taken branch
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,1,  0,1,1,1,1,1,0, 4,1)); // jmp beats DNE
    vecs.push_back(mk(0,0,1,0,3,0,0,1,3,1,  0,1,1,1,1,1,0, 4,2)); // jmp beats hazard
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0,  0,1,1,0,0,1,0, 4,3)); // start in RUN ignored
    vecs.push_back(mk(0,1,0,0,0,0,1,0,0,0,  0,0,0,1,0,1,0, 4,3)); // DNE
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,1,  0,0,0,0,0,1,0, 4,3)); // drain, jmp ignored
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,1,0, 4,3)); // drain
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,1, 4,3)); // done 3 cycles after DNE
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,1,  0,0,0,0,0,0,1, 4,3)); // done held
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,1, 4,3)); // restart from DONE
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  1,1,1,0,0,1,0, 0,0)); // counters cleared
    vecs.push_back(mk(0,0,1,0,3,0,0,1,3,0,  0,0,0,0,1,1,0, 0,0)); // load-use
    vecs.push_back(mk(1,0,1,0,3,0,0,1,3,0,  0,0,0,0,1,1,0, 1,0)); // rst mid-STALL
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0, 0,0)); // IDLE after rst, start
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  1,1,1,0,0,1,0, 0,0)); // clean restart

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].start, vecs[k].ua, vecs[k].ub, vecs[k].pa,
            vecs[k].pb, vecs[k].ack, vecs[k].ld, vecs[k].dst, vecs[k].jmp);
      #1 check($sformatf("vec%0d", k), act, vecs[k].exp);
    end

    // Persistent load-use hazard: PC frozen throughout, stallCnt saturates at 15
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'b0, 0, 1, 0, 3'd3, 2'd0, 0, 1, 3'd3, 0);
      #1 check($sformatf("sat_stall_pcEn%0d", k), {14'd0, bus.pcEn}, 15'd0);
    end
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 3'd0, 0);
    #1 check("sat_stallCnt", act, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd0});

    // Repeated taken branches: flushCnt saturates at 15, PC keeps advancing
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 3'd0, 1);
      #1 check($sformatf("sat_jmp%0d", k), {13'd0, bus.pcEn, bus.ifIdFlush}, 15'd3);
    end
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 3'd0, 0);
    #1 check("sat_flushCnt", act, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd15});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
